// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU data-memory responder.
package cpu_mem_pkg;

  localparam int unsigned REG_WIDTH       = 64;
  localparam int unsigned DWORD_BYTES     = 8;
  localparam int unsigned DMEM_ADDR_WIDTH = 10;
  localparam int unsigned LAT_W           = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  // Request captured at the accept handshake
  typedef struct packed {
    logic                       we;
    logic [DMEM_ADDR_WIDTH-1:0] addr;
    logic [REG_WIDTH-1:0]       wdata;
    logic [DWORD_BYTES-1:0]     wstrb;
  } dmem_req_t;

endpackage

// File: rtl/dmem_array.sv
// Doubleword storage: combinational read, byte-strobed synchronous write.
module dmem_array
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DMEM_DEPTH = 1024,
  parameter int unsigned IDX_W      = $clog2(DMEM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   we_i,
  input  logic [IDX_W-1:0]       addr_i,
  input  logic [REG_WIDTH-1:0]   wdata_i,
  input  logic [DWORD_BYTES-1:0] wstrb_i,
  output logic [REG_WIDTH-1:0]   rdata_c_o
);

  logic [REG_WIDTH-1:0] mem_q [DMEM_DEPTH];

  // Contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < int'(DWORD_BYTES); b++) begin
        if (wstrb_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_c_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency, single-outstanding data-memory responder for the CPU port.
// Optional range checking is enabled by defining DMEM_RANGE_CHECK_EN.
module dmem_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DMEM_DEPTH = 1024,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                       clk,
  input  logic                       reset_b,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [DMEM_ADDR_WIDTH-1:0] req_addr,
  input  logic [REG_WIDTH-1:0]       req_wdata,
  input  logic [DWORD_BYTES-1:0]     req_wstrb,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [REG_WIDTH-1:0]       rsp_rdata,
  output logic                       rsp_err
);

  localparam int unsigned IDX_W = $clog2(DMEM_DEPTH);
  localparam logic [LAT_W-1:0] CNT_INIT = (LATENCY == 0) ? '0 : LAT_W'(LATENCY - 1);

  dmem_state_e          state_q, state_d;
  logic [LAT_W-1:0]     cnt_q, cnt_d;
  dmem_req_t            req_q, req_d;
  logic [REG_WIDTH-1:0] rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;

  dmem_req_t            in_req, cur_req;
  logic                 in_range;
  logic                 commit;
  logic                 mem_we;
  logic [REG_WIDTH-1:0] mem_rdata;

  assign in_req = '{we: req_we, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};

  // With zero latency the commit edge is the accept edge, so use the live request
  assign cur_req = (state_q == ST_IDLE) ? in_req : req_q;

`ifdef DMEM_RANGE_CHECK_EN
  assign in_range = (32'(cur_req.addr) < DMEM_DEPTH);
`else
  assign in_range = 1'b1;
`endif

  dmem_array #(
    .DMEM_DEPTH (DMEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk       (clk),
    .we_i      (mem_we),
    .addr_i    (cur_req.addr[IDX_W-1:0]),
    .wdata_i   (cur_req.wdata),
    .wstrb_i   (cur_req.wstrb),
    .rdata_c_o (mem_rdata)
  );

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_d = in_req;
          if (LATENCY == 0) begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - LAT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Store lands or load data is captured on the edge entering RESP
    if (commit) begin
      mem_we  = cur_req.we && in_range;
      rdata_d = (!cur_req.we && in_range) ? mem_rdata : '0;
      err_d   = !in_range;
    end
  end

  assign req_ready_d = (state_d == ST_IDLE);
  assign rsp_valid_d = (state_d == ST_RESP);

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
